fifo_burst_reader: RTL and testbench
====================================

Name: fifo_burst_reader

Overview:
- Read-side companion to the team's `fifo` block (ports `wen`/`ren`, `data_in`/`data_out`, `data_valid`, `full`/`empty`).
- On a `start` command, pops exactly `len` words from the FIFO and presents them downstream as a valid/ready stream, flagging the final word.
- Absorbs the FIFO's one-cycle read latency with a 2-entry skid buffer. Sustains 1 word/cycle when the FIFO is non-empty and `m_ready` stays high.

Parameters:
- WIDTH, 8, data width; must match the attached `fifo` WIDTH.
- LEN_W, 8, width of the burst-length field; max burst is 2^LEN_W-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  one-cycle burst request; sampled only in IDLE.
- len  input  LEN_W  burst length in words; sampled with `start`.
- busy  output  1  high from the cycle after an accepted `start` until the cycle `done` is asserted, inclusive.
- done  output  1  one-cycle pulse when the burst completes.
- fifo_ren  output  1  read enable to `fifo.ren`.
- fifo_data  input  WIDTH  from `fifo.data_out`.
- fifo_data_valid  input  1  from `fifo.data_valid`; asserted the cycle after a successful `ren`.
- fifo_empty  input  1  from `fifo.empty`.
- m_valid  output  1  output word valid.
- m_data  output  WIDTH  output word.
- m_last  output  1  marks the len-th word; qualified by `m_valid`.
- m_ready  input  1  downstream accept.

Behaviour:
- Reset values: `busy`=0, `done`=0, `fifo_ren`=0, `m_valid`=0, `m_last`=0, `m_data`=0. Reset also clears the state, all counters and the skid buffer.
- States:
  - IDLE -> RUN on `start` with `len`!=0; `len` is latched.
  - IDLE -> DONE on `start` with `len`==0; no FIFO access.
  - RUN -> DONE on the cycle the last word handshakes (`m_valid` & `m_ready` & `m_last`).
  - DONE -> IDLE unconditionally. `done`=1 only in DONE.
- `start` outside IDLE is ignored; the latched `len` is unaffected.
- Counters (each LEN_W bits):
  - `issued`: increments on each `fifo_ren`.
  - `sent`: increments on each output handshake.
  - `inflight`: 1 bit; set on `fifo_ren`, cleared the next cycle.
- `fifo_ren` = RUN & !`fifo_empty` & (`issued` < `len`) & ((`occ` + `inflight` - `pop`) < 2).
  - `occ` is skid-buffer occupancy (0..2).
  - `pop` = `m_valid` & `m_ready`.
  - This credit rule guarantees no returning word is ever dropped.
  - It also permits back-to-back `ren` when `m_ready`=1.
- Data capture:
  - On `fifo_data_valid` in RUN, `fifo_data` is written to the buffer tail.
  - `fifo_data_valid` outside RUN is ignored (stale return after reset).
- Output:
  - `m_valid` = (`occ` != 0); `m_data` = buffer head.
  - `m_last` = (`sent` == `len`-1) & `m_valid`.
  - `m_data`/`m_last` hold stable while `m_valid` & !`m_ready`.
- Latency: first `m_valid` is 2 cycles after `start` if the FIFO is non-empty: `ren` at cycle +1, data registered into the buffer, visible at cycle +2.
- Boundary conditions:
  - FIFO empty mid-burst: `ren` stalls; resumes the cycle `fifo_empty` falls. `m_valid` may drop between words.
  - `occ`==2 with `m_ready`=0: `ren` held low; buffer contents preserved.
  - Simultaneous push and pop with `occ`==1: occupancy stays at 1, order preserved.
  - `len`=2^LEN_W-1: counters must not wrap before completion.
  - Reset mid-burst: returns to IDLE next edge, `m_valid` drops, no `done` pulse. Words already popped from the FIFO are lost.

Decomposition:
- Package `fifo_rd_pkg`:
  - State enum `rd_state_e` {IDLE, RUN, DONE}.
  - Constant `SKID_DEPTH`=2.
- Sub-module `stream_skid_buf` (2-entry, WIDTH-parameterised):
  - Ports: push/data in, valid/ready/data out, `occ` output.
  - Also reusable on other stream outputs.
- Top level holds the FSM, counters and credit logic.

Test Plan:
- FIFO preloaded with 1,2,3,4; `start`, `len`=4, `m_ready`=1 -> `m_data` 1,2,3,4 on 4 consecutive cycles starting at `start`+2. `m_last` only on 4. `done` pulses the cycle after the 4 handshake. FIFO `empty`=1 afterwards.
- FIFO holds 8 words (1..8); `len`=8; `m_ready` toggles 1,0,0,1,... -> all 8 words delivered in order, none duplicated. No `ren` while `occ`+`inflight`=2. FIFO `full` deasserts after the first pop.
- FIFO initially empty; `start` `len`=3; write 0x42 at T+5, 0x43 at T+9, 0x44 at T+10 -> outputs 0x42, 0x43, 0x44 in order. `busy` stays high throughout; `m_last` on 0x44.
- `start` with `len`=0 -> `done` the next cycle; `fifo_ren` never asserted; `m_valid` stays 0.
- `start` `len`=2, then `start` `len`=5 while busy -> exactly 2 words read. FIFO retains the remaining words. Single `done` pulse.
- Assert `rst`=1 for one cycle after 2 of 6 words sent -> `m_valid`=0 and `busy`=0 next cycle, no `done`. A fresh `start` `len`=2 then delivers the next FIFO words correctly.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
// ============================================================================
// Module      : fifo_rd_pkg
// Description : Shared types and constants for the FIFO burst reader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } rd_state_e;

    localparam int SKID_DEPTH = 2;
    localparam int OCC_W      = $clog2(SKID_DEPTH + 1);

endpackage

`default_nettype wire

// File: rtl/stream_skid_buf.sv
// ============================================================================
// Module      : stream_skid_buf
// Description : Two-entry circular skid buffer with valid/ready output side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_skid_buf
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [OCC_W-1:0] o_occ
);

    localparam int PTR_W = $clog2(SKID_DEPTH);

    logic [WIDTH-1:0] r_mem [SKID_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_occ;

    logic w_pop;
    logic w_push_ok;

    assign o_valid   = (r_occ != '0);
    assign o_data    = r_mem[r_rd_ptr];
    assign o_occ     = r_occ;
    assign w_pop     = o_valid & i_ready;
    // A push into a full buffer is only safe when the head leaves the same cycle.
    assign w_push_ok = i_push & ((r_occ != OCC_W'(SKID_DEPTH)) | w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            // Pointers wrap naturally because the depth is a power of two.
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/fifo_burst_reader.sv
// ============================================================================
// Module      : fifo_burst_reader
// Description : Pops a fixed-length burst from a FIFO and streams it out
//               with a last-word flag, hiding the FIFO read latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_burst_reader
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             fifo_ren,
    input  logic [WIDTH-1:0] fifo_data,
    input  logic             fifo_data_valid,
    input  logic             fifo_empty,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    input  logic             m_ready
);

    rd_state_e r_state;
    rd_state_e w_state_nxt;

    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_issued;
    logic [LEN_W-1:0] r_sent;
    logic             r_inflight;

    logic [OCC_W-1:0] w_occ;
    logic             w_pop;
    logic             w_push;
    logic             w_is_last;
    logic [2:0]       w_credit;
    logic             w_ren;

    assign w_pop     = m_valid & m_ready;
    assign w_push    = fifo_data_valid & (r_state == RUN);
    assign w_is_last = (r_sent == (r_len - LEN_W'(1)));

    // Words owed to the buffer after this cycle; a new read needs a free slot.
    assign w_credit  = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_ren     = (r_state == RUN) & ~fifo_empty & (r_issued < r_len)
                     & (w_credit < 3'd2);

    assign fifo_ren  = w_ren;
    assign m_last    = w_is_last & m_valid;
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);

    stream_skid_buf #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (fifo_data),
        .o_valid (m_valid),
        .i_ready (m_ready),
        .o_data  (m_data),
        .o_occ   (w_occ)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = (len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_pop & w_is_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_len      <= '0;
            r_issued   <= '0;
            r_sent     <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_ren;
            if ((r_state == IDLE) && start) begin
                r_len    <= len;
                r_issued <= '0;
                r_sent   <= '0;
            end else begin
                if (w_ren) begin
                    r_issued <= r_issued + LEN_W'(1);
                end
                if (w_pop) begin
                    r_sent <= r_sent + LEN_W'(1);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
// ============================================================================
// Module      : tb_fifo_burst_reader
// Description : Directed self-checking bench for fifo_burst_reader with a
//               behavioural FIFO on the read side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_burst_reader;

    localparam int WIDTH  = 8;
    localparam int LEN_W  = 8;
    localparam int FDEPTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             done;
    logic             fifo_ren;
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_data_valid;
    logic             fifo_empty;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_last;
    logic             m_ready;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fifo_burst_reader #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .len             (len),
        .busy            (busy),
        .done            (done),
        .fifo_ren        (fifo_ren),
        .fifo_data       (fifo_data),
        .fifo_data_valid (fifo_data_valid),
        .fifo_empty      (fifo_empty),
        .m_valid         (m_valid),
        .m_data          (m_data),
        .m_last          (m_last),
        .m_ready         (m_ready)
    );

    // Behavioural FIFO: registered data_out, data_valid one cycle after ren
    logic             f_rst;
    logic             f_wen;
    logic [WIDTH-1:0] f_wdata;
    logic [WIDTH-1:0] f_mem [0:FDEPTH-1];
    int               f_wp, f_rp, f_cnt;
    logic             fifo_full;
    logic             f_wok, f_rok;

    assign fifo_empty = (f_cnt == 0);
    assign fifo_full  = (f_cnt == FDEPTH);
    assign f_wok      = f_wen && (f_cnt < FDEPTH);
    assign f_rok      = fifo_ren && (f_cnt > 0);

    always @(posedge clk) begin
        if (f_rst) begin
            f_wp            <= 0;
            f_rp            <= 0;
            f_cnt           <= 0;
            fifo_data       <= '0;
            fifo_data_valid <= 1'b0;
        end else begin
            if (f_wok) begin
                f_mem[f_wp] <= f_wdata;
                f_wp        <= (f_wp + 1) % FDEPTH;
            end
            if (f_rok) begin
                fifo_data <= f_mem[f_rp];
                f_rp      <= (f_rp + 1) % FDEPTH;
            end
            fifo_data_valid <= f_rok;
            f_cnt           <= f_cnt + int'(f_wok) - int'(f_rok);
        end
    end

    // Output monitor
    logic             mon_clr;
    logic [WIDTH-1:0] got_d [0:15];
    logic             got_l [0:15];
    int               n_hs, ren_cnt, done_cnt, outst;
    logic             ovf;
    logic             hs;

    assign hs = m_valid & m_ready;

    always @(posedge clk) begin
        if (mon_clr) begin
            n_hs     <= 0;
            ren_cnt  <= 0;
            done_cnt <= 0;
            ovf      <= 1'b0;
        end else begin
            if (hs && (n_hs < 16)) begin
                got_d[n_hs] <= m_data;
                got_l[n_hs] <= m_last;
                n_hs        <= n_hs + 1;
            end
            if (fifo_ren) ren_cnt  <= ren_cnt + 1;
            if (done)     done_cnt <= done_cnt + 1;
            if (outst + int'(fifo_ren) - int'(hs) > 2) ovf <= 1'b1;
        end
        outst <= (rst || mon_clr) ? 0 : outst + int'(fifo_ren) - int'(hs);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic fpush(input logic [WIDTH-1:0] d);
        f_wen   = 1'b1;
        f_wdata = d;
        step();
        f_wen   = 1'b0;
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        step();
        mon_clr = 1'b0;
    endtask

    task automatic wait_done(input int bound, input string tag);
        int k;
        k = 0;
        while (!done && (k < bound)) begin
            step();
            k++;
        end
        chk({tag, "_done_seen"}, 32'(done), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int k;
        logic busy_drop;

        rst = 1'b1; f_rst = 1'b1; mon_clr = 1'b1;
        start = 1'b0; len = '0; m_ready = 1'b0; f_wen = 1'b0; f_wdata = '0;
        step();
        step();
        chk("reset_outputs", {20'd0, busy, done, fifo_ren, m_valid, m_last, m_data},
            32'd0);
        rst = 1'b0; f_rst = 1'b0; mon_clr = 1'b0;
        step();

        // ---- Burst of 4 at full rate ----
        for (int i = 1; i <= 4; i++) fpush(8'(i));
        m_ready = 1'b1;
        clear_mon();
        start = 1'b1; len = 8'd4;
        step();
        start = 1'b0;
        chk("t1_busy_e0", 32'(busy), 32'd1);
        chk("t1_ren_e0", 32'(fifo_ren), 32'd1);
        chk("t1_mvalid_e0", 32'(m_valid), 32'd0);
        step();
        chk("t1_mvalid_e1", 32'(m_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t1_mvalid", 32'(m_valid), 32'd1);
            chk("t1_mdata", 32'(m_data), 32'(i + 1));
            chk("t1_mlast", 32'(m_last), 32'(i == 3));
        end
        step();
        chk("t1_done", {30'd0, done, m_valid}, {30'd0, 1'b1, 1'b0});
        step();
        chk("t1_idle", {30'd0, done, busy}, 32'd0);
        chk("t1_fifo_empty", 32'(fifo_empty), 32'd1);
        chk("t1_done_cnt", 32'(done_cnt), 32'd1);

        // ---- Burst of 8 with throttled downstream ----
        clear_mon();
        for (int i = 1; i <= 8; i++) fpush(8'(i));
        chk("t2_full_pre", 32'(fifo_full), 32'd1);
        m_ready = 1'b0;
        start = 1'b1; len = 8'd8;
        step();
        start = 1'b0;
        step();
        chk("t2_full_after_pop", 32'(fifo_full), 32'd0);
        c = 0;
        while (!done && (c < 80)) begin
            m_ready = ((c % 3) == 0);
            step();
            c++;
        end
        chk("t2_done_seen", 32'(done), 32'd1);
        m_ready = 1'b1;
        step();
        chk("t2_count", 32'(n_hs), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk("t2_data", 32'(got_d[i]), 32'(i + 1));
            chk("t2_last", 32'(got_l[i]), 32'(i == 7));
        end
        chk("t2_no_overrun", 32'(ovf), 32'd0);
        chk("t2_ren_cnt", 32'(ren_cnt), 32'd8);
        chk("t2_done_cnt", 32'(done_cnt), 32'd1);

        // ---- Starved FIFO: words trickle in ----
        clear_mon();
        busy_drop = 1'b0;
        start = 1'b1; len = 8'd3;
        step();
        start = 1'b0;
        c = 1;
        while (!done && (c < 40)) begin
            f_wen   = (c == 5) || (c == 9) || (c == 10);
            f_wdata = (c == 5) ? 8'h42 : ((c == 9) ? 8'h43 : 8'h44);
            step();
            if (!busy) busy_drop = 1'b1;
            c++;
        end
        f_wen = 1'b0;
        chk("t3_done_seen", 32'(done), 32'd1);
        step();
        chk("t3_busy_held", 32'(busy_drop), 32'd0);
        chk("t3_count", 32'(n_hs), 32'd3);
        chk("t3_d0", 32'(got_d[0]), 32'h42);
        chk("t3_d1", 32'(got_d[1]), 32'h43);
        chk("t3_d2", 32'(got_d[2]), 32'h44);
        chk("t3_lasts", {29'd0, got_l[0], got_l[1], got_l[2]}, 32'b001);
        chk("t3_ren_cnt", 32'(ren_cnt), 32'd3);

        // ---- Zero-length burst ----
        for (int i = 0; i < 5; i++) fpush(8'(8'h10 + i));
        clear_mon();
        start = 1'b1; len = 8'd0;
        step();
        start = 1'b0;
        chk("t4_done", {29'd0, done, busy, m_valid}, 32'b110);
        step();
        chk("t4_idle", {30'd0, done, busy}, 32'd0);
        chk("t4_no_ren", 32'(ren_cnt), 32'd0);
        chk("t4_fifo_cnt", 32'(f_cnt), 32'd5);
        chk("t4_no_out", 32'(n_hs), 32'd0);

        // ---- Start while busy is ignored ----
        clear_mon();
        start = 1'b1; len = 8'd2;
        step();
        len = 8'd5;
        step();
        start = 1'b0;
        wait_done(20, "t5");
        step();
        step();
        chk("t5_count", 32'(n_hs), 32'd2);
        chk("t5_d0", 32'(got_d[0]), 32'h10);
        chk("t5_d1", 32'(got_d[1]), 32'h11);
        chk("t5_lasts", {30'd0, got_l[0], got_l[1]}, 32'b01);
        chk("t5_done_cnt", 32'(done_cnt), 32'd1);
        chk("t5_ren_cnt", 32'(ren_cnt), 32'd2);
        chk("t5_fifo_left", 32'(f_cnt), 32'd3);

        // ---- Reset mid-burst, then a fresh burst ----
        fpush(8'h15); fpush(8'h16); fpush(8'h17);
        clear_mon();
        start = 1'b1; len = 8'd6;
        step();
        start = 1'b0;
        k = 0;
        while ((n_hs < 2) && (k < 20)) begin
            step();
            k++;
        end
        chk("t6_two_sent", 32'(n_hs), 32'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_after_rst", {29'd0, m_valid, busy, done}, 32'd0);
        chk("t6_fifo_left", 32'(f_cnt), 32'd1);
        fpush(8'h20);
        chk("t6_no_done", {31'd0, done}, 32'd0);
        clear_mon();
        start = 1'b1; len = 8'd2;
        step();
        start = 1'b0;
        wait_done(20, "t6");
        step();
        step();
        chk("t6_count", 32'(n_hs), 32'd2);
        chk("t6_d0", 32'(got_d[0]), 32'h17);
        chk("t6_d1", 32'(got_d[1]), 32'h20);
        chk("t6_lasts", {30'd0, got_l[0], got_l[1]}, 32'b01);
        chk("t6_done_cnt", 32'(done_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
